uart_tx_fifo: RTL and testbench

Parametrised successor to the team's fixed 8N1 RS-232 transmitter.
- Adds configurable data width, optional odd/even parity, 1 or 2 stop bits, and a small input FIFO with a valid/ready handshake.
- Adds back-to-back framing with no idle gap.
- Sits between host-side logic (debug/telemetry streams) and the board TxD pin.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Parametrised UART transmitter with a small valid/ready input FIFO.
//            Configurable data bits, parity and stop bits; frames back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    localparam int                 c_aw       = $clog2(FIFO_DEPTH);
    localparam longint             c_inc_l    = ((longint'(BAUD) << (ACC_WIDTH - 4)) +
                                                 (longint'(CLK_FREQ) >> 5)) /
                                                (longint'(CLK_FREQ) >> 4);
    localparam logic [ACC_WIDTH:0] c_inc      = c_inc_l[ACC_WIDTH:0];
    localparam logic [c_aw:0]      c_depth    = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [3:0]         c_last_bit = 4'(DATA_BITS - 1);
    localparam logic               c_last_stop = 1'(STOP_BITS - 1);
    localparam logic               c_odd      = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]        r_count, w_count_next;
    logic                 r_ready;

    state_t               r_state;
    logic [ACC_WIDTH:0]   r_acc;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bitcnt;
    logic                 r_stopcnt;
    logic                 r_par;
    logic                 r_txd;

    logic                 w_tick, w_push, w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign w_tick = r_acc[ACC_WIDTH];
    assign w_push = tx_valid && r_ready;
    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = (r_count != '0) &&
                    ((r_state == S_IDLE) ||
                     (r_state == S_STOP && w_tick && r_stopcnt == c_last_stop));

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_depth);
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_txd <= 1'b0;
                S_DATA:  r_txd <= r_shift[0];
                S_PAR:   r_txd <= r_par;
                default: r_txd <= 1'b1;
            endcase

            r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + c_inc;

            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    if (w_pop) begin
                        // The launch edge is the first accumulation step of the start bit.
                        r_acc     <= c_inc;
                        r_shift   <= w_head;
                        r_bitcnt  <= '0;
                        r_stopcnt <= 1'b0;
                        r_par     <= (^w_head) ^ c_odd;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == c_last_bit) begin
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end
                    end
                end
                S_PAR: begin
                    if (w_tick) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stopcnt == c_last_stop) begin
                            if (w_pop) begin
                                r_shift   <= w_head;
                                r_bitcnt  <= '0;
                                r_stopcnt <= 1'b0;
                                r_par     <= (^w_head) ^ c_odd;
                                r_state   <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stopcnt <= r_stopcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign txd        = r_txd;
    assign tx_ready   = r_ready;
    assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed bench for uart_tx_fifo; four configurations (8N1, 8E1,
//            8O1, 7N2) decoded by a mid-bit sampler against an expected queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DB [4] = '{8, 8, 8, 7};
    localparam int PM [4] = '{0, 2, 1, 0};
    localparam int SB [4] = '{1, 1, 1, 2};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      valid_v = '0;
    logic [3:0][7:0] data_v = '0;
    wire  [3:0]      ready_v, txd_v, busy_v;
    wire  [3:0][2:0] cnt_v;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];
    logic [7:0] b6 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[0]), .tx_data(data_v[0]),
        .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[1]), .tx_data(data_v[1]),
        .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[2]), .tx_data(data_v[2]),
        .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[3]), .tx_data(data_v[3][6:0]),
        .tx_ready(ready_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .fifo_count(cnt_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling clock edge; expected data enters the queue at the push edge.
    task automatic push(input int idx, input logic [7:0] d, input bit hold);
        int w;
        w = 0;
        valid_v[idx] = 1'b1;
        data_v[idx]  = d;
        while (ready_v[idx] !== 1'b1 && w < 1000) begin
            chk("ready_low_only_when_full", 32'(cnt_v[idx]), 32'd4);
            @(negedge clk);
            w++;
        end
        chk("push_accepted", 32'(ready_v[idx]), 32'd1);
        @(posedge clk);
        exp_q.push_back((DB[idx] == 7) ? (d & 8'h7F) : d);
        @(negedge clk);
        if (!hold) valid_v[idx] = 1'b0;
    endtask

    task automatic wait_fall(input int idx, output int waited);
        waited = 0;
        while (txd_v[idx] !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("start_edge_seen", 32'(txd_v[idx]), 32'd0);
    endtask

    task automatic rx(input int idx, output int waited);
        logic [7:0] got, exp;
        wait_fall(idx, waited);
        repeat (8) @(negedge clk);
        chk("start_bit", 32'(txd_v[idx]), 32'd0);
        got = '0;
        for (int i = 0; i < DB[idx]; i++) begin
            repeat (16) @(negedge clk);
            got[i] = txd_v[idx];
        end
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        chk("data", 32'(got), 32'(exp));
        if (PM[idx] != 0) begin
            repeat (16) @(negedge clk);
            chk("parity_bit", 32'(txd_v[idx]), 32'((^exp) ^ (PM[idx] == 1)));
        end
        for (int s = 0; s < SB[idx]; s++) begin
            repeat (16) @(negedge clk);
            chk("stop_bit", 32'(txd_v[idx]), 32'd1);
        end
    endtask

    task automatic check_end(input int idx);
        repeat (6) @(negedge clk);
        chk("busy_before_frame_end", 32'(busy_v[idx]), 32'd1);
        @(negedge clk);
        chk("busy_after_frame_end", 32'(busy_v[idx]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic seen_low;

        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd_v), 32'hF);
        chk("reset_ready", 32'(ready_v), 32'h0);
        chk("reset_busy", 32'(busy_v), 32'h0);
        chk("reset_count", 32'(cnt_v[0]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", 32'(ready_v), 32'hF);
        chk("idle_txd", 32'(txd_v), 32'hF);

        push(0, 8'h55, 1'b0);
        rx(0, w);
        chk("start_latency", 32'(w), 32'd2);
        check_end(0);

        push(1, 8'h55, 1'b0);
        rx(1, w);
        check_end(1);
        push(1, 8'h01, 1'b0);
        rx(1, w);
        check_end(1);

        push(2, 8'h55, 1'b0);
        rx(2, w);
        check_end(2);

        push(3, 8'h41, 1'b0);
        rx(3, w);
        check_end(3);

        fork
            begin
                for (int i = 0; i < 6; i++) push(0, b6[i], i < 5);
            end
            begin
                int w2;
                for (int j = 0; j < 6; j++) begin
                    rx(0, w2);
                    if (j > 0) chk("b2b_no_gap", 32'(w2), 32'd8);
                end
            end
        join
        check_end(0);
        chk("b2b_count_drained", 32'(cnt_v[0]), 32'd0);

        push(0, 8'h5A, 1'b1);
        chk("count_after_first_push", 32'(cnt_v[0]), 32'd1);
        push(0, 8'hA5, 1'b0);
        chk("count_push_pop_same_edge", 32'(cnt_v[0]), 32'd1);
        rx(0, w);
        rx(0, w);
        chk("pushpop_no_gap", 32'(w), 32'd8);
        check_end(0);

        push(0, 8'h00, 1'b1);
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b0);
        wait_fall(0, w);
        repeat (8 + 16 * 4) @(negedge clk);
        chk("bit3_low_before_reset", 32'(txd_v[0]), 32'd0);
        chk("two_queued_before_reset", 32'(cnt_v[0]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_txd", 32'(txd_v[0]), 32'd1);
        chk("async_reset_count", 32'(cnt_v[0]), 32'd0);
        chk("async_reset_ready", 32'(ready_v[0]), 32'd0);
        chk("async_reset_busy", 32'(busy_v[0]), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen_low = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_low = seen_low | ~txd_v[0] | busy_v[0];
        end
        chk("idle_after_reset", 32'(seen_low), 32'd0);
        push(0, 8'h3C, 1'b0);
        rx(0, w);
        chk("latency_after_reset", 32'(w), 32'd2);
        check_end(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
